bypass_regfile: RTL
===================

BYPASS_REGFILE -- requirements
Module: bypass_regfile

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, reset, synchronous, active-low.
- rd_addr, in, NRD*ADDR_W, read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data, out, NRD*DATA_W, read data per port.
- rd_ready, out, NRD, 1 = operand at rd_addr[k] is valid this cycle (not pending).
- wr_en, in, NWR, write enable per write port.
- wr_addr, in, NWR*ADDR_W, write addresses.
- wr_data, in, NWR*DATA_W, write data.
- iss_en, in, 1, issue: mark iss_addr as pending a future write.
- iss_addr, in, ADDR_W, destination register being issued.
- wr_collide, out, 1, registered pulse: the previous cycle had two or more enabled write ports targeting the same address.

Function
REQ-003 Storage SHALL be DEPTH x DATA_W registers plus DEPTH busy bits, all updated only on the rising edge of clk.
REQ-004 Reads SHALL be combinational, with zero-cycle latency from rd_addr, wr_*, and state to rd_data and rd_ready.
REQ-005 Bypass: if any wr_en[j] is set with wr_addr[j] == rd_addr[k], then rd_data[k] SHALL equal wr_data[j] of the highest such j; otherwise it SHALL equal the stored value.
REQ-006 rd_ready[k] SHALL be 1 when busy[rd_addr[k]] == 0 or a same-cycle write to rd_addr[k] is bypassed (REQ-005); otherwise it SHALL be 0.
REQ-007 Write: for each address, the register SHALL take wr_data of the highest-index enabled port addressing it; lower-index colliding ports SHALL be discarded.
REQ-008 wr_collide SHALL be 1 in cycle t+1 iff two or more ports were enabled with equal wr_addr in cycle t; it SHALL be 0 otherwise.
REQ-009 Busy set: iss_en in cycle t SHALL set busy[iss_addr] at edge t+1.
REQ-010 Busy clear: any enabled write to address a in cycle t SHALL clear busy[a] at edge t+1.
REQ-011 When issue and write target the same address in the same cycle, the write SHALL update data and the busy bit SHALL end set, because the issue has priority as the newer producer.
REQ-012 Repeated iss_en to an already-busy register SHALL leave it busy; no count is kept, and a single write clears it.
REQ-013 A write to a non-busy register SHALL be accepted normally.
REQ-014 With ZERO_REG=1, writes to address 0 SHALL be ignored, iss_en to address 0 SHALL be ignored, reads of address 0 SHALL return 0 with rd_ready=1 with no bypass, and address-0 collisions SHALL still assert wr_collide.
REQ-015 With ZERO_REG=0, address 0 SHALL behave as an ordinary register.
REQ-016 All read ports SHALL be independent; the same address on several ports SHALL return identical data and ready values.

Reset
REQ-017 While rst=0 at a rising edge, all registers SHALL become 0, all busy bits SHALL become 0, and wr_collide SHALL become 0; writes and issues in that cycle SHALL be discarded.
REQ-018 While rst=0, bypass SHALL be disabled, so rd_data shows stored contents and rd_ready follows the busy bits only.
REQ-019 Reset asserted mid-operation with pending busy bits SHALL clear them, and all rd_ready SHALL read 1 in the first cycle after reset.

Verification
REQ-020 Reset then basic write/read: hold rst=0 for 2 cycles, release; write port0 addr 5 = 0xDEADBEEF; next cycle read port1 addr 5 -> 0xDEADBEEF, rd_ready=1.
REQ-021 Bypass and collision: in one cycle, port0 writes addr 7 = 0x11 and port1 writes addr 7 = 0x22, with read addr 7.
- Same cycle: rd_data=0x22, rd_ready=1.
- Next cycle: stored value 0x22 and wr_collide=1.
- Following cycle: wr_collide=0.
REQ-022 Scoreboard: iss_en with addr 9; next cycle read 9 -> rd_ready=0; write addr 9 = 0x5A -> same cycle rd_ready=1 and rd_data=0x5A; next cycle busy clear with rd_ready=1.
REQ-023 Same-cycle issue and write on addr 3 (write 0x77) -> next cycle stored value 0x77 and rd_ready[addr 3]=0.
REQ-024 Zero register with ZERO_REG=1: write addr 0 = 0xFFFFFFFF and iss_en addr 0 -> read addr 0 returns 0 with rd_ready=1, both in the same cycle and the next.
REQ-025 Reset mid-operation: set busy on addrs 4 and 6 and write addr 4 = 0x99, then pulse rst=0 together with a write to addr 6 = 0x33 -> after release, addrs 4 and 6 read 0 with rd_ready=1.

Source files
------------

// File: rtl/bypass_regfile.sv
// rtl/bypass_regfile.sv - multi-port register file with write-to-read bypass and busy scoreboard
// Highest-index write port wins on address collisions; issue beats write for the busy bit.
module bypass_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_ready,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*ADDR_W-1:0]   wr_addr,
  input  logic [NWR*DATA_W-1:0]   wr_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    wr_collide
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              collide_q;
  logic              collide_d;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read side: ascending scan so the highest matching write port overrides.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic [DATA_W-1:0] byp;
    rd_data  = '0;
    rd_ready = '0;
    for (int k = 0; k < NRD; k++) begin
      a   = rd_addr[k*ADDR_W +: ADDR_W];
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NWR; j++) begin
        if (rst && wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
          hit = 1'b1;
          byp = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (is_zero_reg(a)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_ready[k]                 = 1'b1;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = hit ? byp : regs_q[a];
        rd_ready[k]                 = !busy_q[a] || hit;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] wa;
    regs_d    = regs_q;
    busy_d    = busy_q;
    collide_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      wa = wr_addr[j*ADDR_W +: ADDR_W];
      if (wr_en[j] && !is_zero_reg(wa)) begin
        regs_d[wa] = wr_data[j*DATA_W +: DATA_W];
        busy_d[wa] = 1'b0;
      end
    end
    // Issue is applied after writes so a same-cycle newer producer keeps the register busy.
    if (iss_en && !is_zero_reg(iss_addr)) begin
      busy_d[iss_addr] = 1'b1;
    end
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
          collide_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  assign wr_collide = collide_q;

endmodule
